// File: rtl/fpcvt_pkg.sv
// Shared definitions for the pipelined integer to sign/exponent/mantissa converter.
package fpcvt_pkg;

  // Rounding-mode encodings carried with every word
  localparam logic RM_HALF_UP = 1'b0;
  localparam logic RM_TRUNC   = 1'b1;

  // Per-word control tag that travels unchanged through every stage.
  // Stage payloads wrap this tag together with their width-dependent
  // data (mag, or {e, F, r, sticky}) inside the parameterised top.
  typedef struct packed {
    logic sign;
    logic rm;
    logic forcesat;
  } tag_t;

  // Bits needed for the internal exponent value, including the rounding
  // carry: the largest value is (dw-1) - (mw-1) - 1 + 1 = dw - mw.
  function automatic int exp_val_width(input int dw, input int mw);
    return $clog2(dw - mw + 1);
  endfunction

endpackage

// File: rtl/fpcvt_lzd.sv
// Leading-one detector: index of the most significant set bit, plus a zero flag.
module fpcvt_lzd #(
  parameter int W  = 11,
  parameter int PW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  a,
  output logic [PW-1:0] p,
  output logic          zero
);

  // Scan upward so the highest set bit is the last one to win
  always_comb begin
    p = '0;
    for (int i = 0; i < W; i++) begin
      p = a[i] ? PW'(i) : p;
    end
    zero = (a == '0);
  end

endmodule

// File: rtl/fpcvt_pipe.sv
// Three-stage converter: sign/magnitude, normalise, round/saturate, with
// per-stage valid bits, full backpressure and bubble collapsing.
module fpcvt_pipe
  import fpcvt_pkg::*;
#(
  parameter int DW = 12,
  parameter int EW = 3,
  parameter int MW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] D,
  input  logic          RM,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          S,
  output logic [EW-1:0] E,
  output logic [MW-1:0] F,
  output logic          X,
  output logic          SAT
);

  localparam int MAGW = DW - 1;
  localparam int EIW  = exp_val_width(DW, MW);
  localparam int PW   = $clog2(MAGW);
  localparam int EMAX = (1 << EW) - 1;

  typedef struct packed {
    tag_t            tag;
    logic [MAGW-1:0] mag;
  } s1_t;

  typedef struct packed {
    tag_t           tag;
    logic [EIW-1:0] e;
    logic [MW-1:0]  f;
    logic           r;
    logic           sticky;
  } s2_t;

  typedef struct packed {
    logic          s;
    logic [EW-1:0] e;
    logic [MW-1:0] f;
    logic          x;
    logic          sat;
  } s3_t;

  logic            v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  s1_t             s1_q, s1_d, s1_new_s;
  s2_t             s2_q, s2_d, s2_new_s;
  s3_t             s3_q, s3_d, s3_new_s;
  logic            ld1_s, ld2_s, ld3_s;
  logic [PW-1:0]   lead_s;
  logic            zero_s, small_s;
  logic [EIW-1:0]  e_norm_s, e_rnd_s;
  logic [MAGW-1:0] low_mask_s;
  logic [MW-1:0]   f_rnd_s;
  logic            round_up_s, f_full_s, sat_s;

  // Occupancy chain: a stage loads when empty or when its successor loads
  always_comb begin
    ld3_s    = ~v3_q | out_ready;
    ld2_s    = ~v2_q | ld3_s;
    ld1_s    = ~v1_q | ld2_s;
    in_ready = ld1_s;
  end

  // Stage 1: sign and magnitude; the most negative input has no magnitude
  // in DW-1 bits, so it is clamped and tagged for forced saturation
  always_comb begin
    s1_new_s.tag.sign     = D[DW-1];
    s1_new_s.tag.rm       = RM;
    s1_new_s.tag.forcesat = D[DW-1] & ~(|D[MAGW-1:0]);
    if (s1_new_s.tag.forcesat) begin
      s1_new_s.mag = '1;
    end else if (D[DW-1]) begin
      s1_new_s.mag = ~D[MAGW-1:0] + MAGW'(1);
    end else begin
      s1_new_s.mag = D[MAGW-1:0];
    end
  end

  fpcvt_lzd #(.W(MAGW), .PW(PW)) u_lzd (
    .a    (s1_q.mag),
    .p    (lead_s),
    .zero (zero_s)
  );

  // Stage 2: shift the leading one into the top mantissa bit and collect
  // the round bit and sticky OR of everything below it
  always_comb begin
    small_s = zero_s | (int'(lead_s) < MW);
    if (small_s) begin
      e_norm_s     = '0;
      s2_new_s.r   = 1'b0;
      low_mask_s   = '0;
    end else begin
      e_norm_s     = EIW'(int'(lead_s) - (MW - 1));
      s2_new_s.r   = 1'(s1_q.mag >> (e_norm_s - EIW'(1)));
      low_mask_s   = (MAGW'(1) << (e_norm_s - EIW'(1))) - MAGW'(1);
    end
    s2_new_s.tag    = s1_q.tag;
    s2_new_s.e      = e_norm_s;
    s2_new_s.f      = MW'(s1_q.mag >> e_norm_s);
    s2_new_s.sticky = |(s1_q.mag & low_mask_s);
  end

  // Stage 3: optional half-up increment with mantissa renormalisation,
  // then clamp on exponent overflow or a forced-saturation tag
  always_comb begin
    round_up_s = (s2_q.tag.rm == RM_HALF_UP) & s2_q.r;
    f_full_s   = &s2_q.f;
    if (round_up_s & f_full_s) begin
      f_rnd_s = {1'b1, {(MW-1){1'b0}}};
      e_rnd_s = s2_q.e + EIW'(1);
    end else if (round_up_s) begin
      f_rnd_s = s2_q.f + MW'(1);
      e_rnd_s = s2_q.e;
    end else begin
      f_rnd_s = s2_q.f;
      e_rnd_s = s2_q.e;
    end
    sat_s        = s2_q.tag.forcesat | (int'(e_rnd_s) > EMAX);
    s3_new_s.s   = s2_q.tag.sign;
    s3_new_s.e   = sat_s ? '1 : EW'(e_rnd_s);
    s3_new_s.f   = sat_s ? '1 : f_rnd_s;
    s3_new_s.x   = s2_q.r | s2_q.sticky | sat_s;
    s3_new_s.sat = sat_s;
  end

  // Next state: valid bits follow the load enables; payloads only move
  // when a real word arrives, so a stalled output holds its value
  always_comb begin
    v1_d = ld1_s ? in_valid : v1_q;
    v2_d = ld2_s ? v1_q : v2_q;
    v3_d = ld3_s ? v2_q : v3_q;
    s1_d = (ld1_s & in_valid) ? s1_new_s : s1_q;
    s2_d = (ld2_s & v1_q) ? s2_new_s : s2_q;
    s3_d = (ld3_s & v2_q) ? s3_new_s : s3_q;
  end

  // Pipeline registers; reset empties every stage and zeroes the outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign out_valid = v3_q;
  assign S         = s3_q.s;
  assign E         = s3_q.e;
  assign F         = s3_q.f;
  assign X         = s3_q.x;
  assign SAT       = s3_q.sat;

endmodule

// File: tb/tb_fpcvt_pipe.sv
// Bench for fpcvt_pipe at DW=12, EW=3, MW=4: vector table, streaming,
// backpressure, bubble collapse and mid-stream reset, all scored in order.
module tb_fpcvt_pipe;
  import fpcvt_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] D = 12'h000;
  logic        RM = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        S, X, SAT;
  logic [2:0]  E;
  logic [3:0]  F;

  typedef struct packed {
    logic       s;
    logic [2:0] e;
    logic [3:0] f;
    logic       x;
    logic       sat;
  } res_t;

  typedef struct packed {
    logic [11:0] d;
    logic        rm;
    res_t        r;
  } vec_t;

  res_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_deliv = 0;
  int   first_cyc = -1;
  int   last_cyc = -1;
  int   first_acc = -1;
  res_t hold_snap;
  bit   hold_prev = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  fpcvt_pipe #(.DW(12), .EW(3), .MW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .D         (D),
    .RM        (RM),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .E         (E),
    .F         (F),
    .X         (X),
    .SAT       (SAT)
  );

  // Reference: shift the magnitude right one bit at a time, tracking round and sticky
  function automatic res_t model(input logic [11:0] d, input logic rm);
    res_t o;
    int   m, e;
    bit   r, st;
    o.s = d[11];
    if (d == 12'h800) begin
      o.e = 3'd7; o.f = 4'hF; o.x = 1'b1; o.sat = 1'b1;
      return o;
    end
    m = d[11] ? (4096 - int'(d)) : int'(d);
    e = 0; r = 1'b0; st = 1'b0;
    while (m >= 16) begin
      st = st | r;
      r  = (m % 2) == 1;
      m  = m / 2;
      e++;
    end
    if (rm == 1'b0 && r) begin
      m++;
      if (m == 16) begin
        m = 8;
        e++;
      end
    end
    if (e > 7) begin
      o.e = 3'd7; o.f = 4'hF; o.x = 1'b1; o.sat = 1'b1;
    end else begin
      o.e = 3'(e); o.f = 4'(m); o.x = r | st; o.sat = 1'b0;
    end
    return o;
  endfunction

  function automatic vec_t mk(input logic [11:0] d, input logic rm, input logic s,
                              input logic [2:0] e, input logic [3:0] f,
                              input logic x, input logic sat);
    vec_t v;
    v.d = d; v.rm = rm;
    v.r.s = s; v.r.e = e; v.r.f = f; v.r.x = x; v.r.sat = sat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output monitor: score every delivered word; check held outputs during stalls
  always @(negedge clk) begin
    res_t got, exp_r;
    got = {S, E, F, X, SAT};
    if (rst) begin
      hold_prev = 1'b0;
    end else if (out_valid && out_ready) begin
      n_deliv++;
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
      hold_prev = 1'b0;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0h with nothing expected (t=%0t)", got, $time);
      end else begin
        exp_r = sb.pop_front();
        chk("result {S,E,F,X,SAT}", 32'(got), 32'(exp_r));
      end
    end else if (out_valid) begin
      if (hold_prev) chk("hold_stable", 32'(got), 32'(hold_snap));
      hold_snap = got;
      hold_prev = 1'b1;
    end else begin
      hold_prev = 1'b0;
    end
  end

  // One clock: drive just after the rising edge, judge acceptance at the falling edge
  task automatic step(input logic v, input logic [11:0] d, input logic rm,
                      input logic ordy, input res_t ex, output bit acc);
    @(posedge clk);
    #1;
    in_valid = v; D = d; RM = rm; out_ready = ordy;
    @(negedge clk);
    acc = v && in_ready;
    if (acc) begin
      sb.push_back(ex);
      if (first_acc < 0) first_acc = cyc;
    end
  endtask

  task automatic send(input logic [11:0] d, input logic rm, input res_t ex, input logic ordy);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 100) begin
      step(1'b1, d, rm, ordy, ex, acc);
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: word %0h not accepted in 100 cycles", d);
    end
  endtask

  task automatic idle(input int n, input logic ordy);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 12'h000, 1'b0, ordy, res_t'(10'h000), acc);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      idle(1, 1'b1);
      n++;
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
    idle(3, 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; in_valid = 1'b1; D = 12'h123; out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    sb.delete();
    n_deliv = 0; first_cyc = -1; last_cyc = -1; first_acc = -1;
    @(negedge clk);
  endtask

  initial begin
    vec_t        tbl[18];
    logic [11:0] w[6];
    logic        wr[6];
    logic [11:0] d;
    logic        rm;
    int          k, n, nb;
    bit          acc;

    tbl[0]  = mk(12'h000, RM_HALF_UP, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0);
    tbl[1]  = mk(12'hFFF, RM_HALF_UP, 1'b1, 3'd0, 4'b0001, 1'b0, 1'b0);
    tbl[2]  = mk(12'h06C, RM_HALF_UP, 1'b0, 3'd3, 4'b1110, 1'b1, 1'b0);
    tbl[3]  = mk(12'h06C, RM_TRUNC,   1'b0, 3'd3, 4'b1101, 1'b1, 1'b0);
    tbl[4]  = mk(12'h0F8, RM_HALF_UP, 1'b0, 3'd5, 4'b1000, 1'b1, 1'b0);
    tbl[5]  = mk(12'h0F8, RM_TRUNC,   1'b0, 3'd4, 4'b1111, 1'b1, 1'b0);
    tbl[6]  = mk(12'h7FF, RM_HALF_UP, 1'b0, 3'd7, 4'b1111, 1'b1, 1'b1);
    tbl[7]  = mk(12'h7FF, RM_TRUNC,   1'b0, 3'd7, 4'b1111, 1'b1, 1'b0);
    tbl[8]  = mk(12'h800, RM_HALF_UP, 1'b1, 3'd7, 4'b1111, 1'b1, 1'b1);
    tbl[9]  = mk(12'h800, RM_TRUNC,   1'b1, 3'd7, 4'b1111, 1'b1, 1'b1);
    tbl[10] = mk(12'h00F, RM_HALF_UP, 1'b0, 3'd0, 4'b1111, 1'b0, 1'b0);
    tbl[11] = mk(12'h010, RM_HALF_UP, 1'b0, 3'd1, 4'b1000, 1'b0, 1'b0);
    tbl[12] = mk(12'h011, RM_HALF_UP, 1'b0, 3'd1, 4'b1001, 1'b1, 1'b0);
    tbl[13] = mk(12'h011, RM_TRUNC,   1'b0, 3'd1, 4'b1000, 1'b1, 1'b0);
    tbl[14] = mk(12'hF94, RM_HALF_UP, 1'b1, 3'd3, 4'b1110, 1'b1, 1'b0);
    tbl[15] = mk(12'h3FF, RM_HALF_UP, 1'b0, 3'd7, 4'b1000, 1'b1, 1'b0);
    tbl[16] = mk(12'h400, RM_HALF_UP, 1'b0, 3'd7, 4'b1000, 1'b0, 1'b0);
    tbl[17] = mk(12'h801, RM_HALF_UP, 1'b1, 3'd7, 4'b1111, 1'b1, 1'b1);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_outputs", 32'({S, E, F, X, SAT}), 32'd0);

    // Table vectors, back to back
    foreach (tbl[i]) send(tbl[i].d, tbl[i].rm, tbl[i].r, 1'b1);
    drain();

    // Streaming: latency and throughput
    do_reset();
    for (int i = 0; i < 6; i++) begin
      d  = 12'($urandom);
      rm = 1'($urandom);
      send(d, rm, model(d, rm), 1'b1);
    end
    drain();
    chk("latency_edges", 32'(first_cyc - first_acc), 32'd3);
    chk("throughput_span", 32'(last_cyc - first_cyc), 32'd5);
    chk("stream_count", 32'(n_deliv), 32'd6);

    // Backpressure: five stalled cycles take exactly three words
    do_reset();
    for (int i = 0; i < 6; i++) begin
      w[i]  = 12'($urandom);
      wr[i] = 1'($urandom);
    end
    k = 0;
    for (int c = 0; c < 5; c++) begin
      step(1'b1, w[k], wr[k], 1'b0, model(w[k], wr[k]), acc);
      if (acc) k++;
    end
    chk("bp_accepted", 32'(k), 32'd3);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_no_delivery", 32'(n_deliv), 32'd0);
    n = 0;
    while (k < 6 && n < 100) begin
      step(1'b1, w[k], wr[k], 1'b1, model(w[k], wr[k]), acc);
      if (acc) k++;
      n++;
    end
    drain();
    chk("bp_delivered", 32'(n_deliv), 32'd6);

    // Bubble collapse
    do_reset();
    send(12'h06C, RM_HALF_UP, model(12'h06C, RM_HALF_UP), 1'b0);
    idle(2, 1'b0);
    chk("bubble_ready_after_idle", 32'(in_ready), 32'd1);
    send(12'hF94, RM_TRUNC, model(12'hF94, RM_TRUNC), 1'b0);
    idle(1, 1'b0);
    chk("bubble_ready_two_resident", 32'(in_ready), 32'd1);
    send(12'h0F8, RM_HALF_UP, model(12'h0F8, RM_HALF_UP), 1'b0);
    idle(1, 1'b0);
    chk("bubble_full_ready", 32'(in_ready), 32'd0);
    chk("bubble_full_valid", 32'(out_valid), 32'd1);
    drain();
    chk("bubble_delivered", 32'(n_deliv), 32'd3);

    // Reset with three words in flight
    do_reset();
    for (int i = 0; i < 3; i++) begin
      d = 12'($urandom);
      send(d, 1'b0, model(d, 1'b0), 1'b0);
    end
    do_reset();
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_outputs", 32'({S, E, F, X, SAT}), 32'd0);
    nb = n_deliv;
    idle(6, 1'b1);
    chk("midrst_nothing_emerges", 32'(n_deliv), 32'(nb));

    // Random traffic with random bubbles and stalls
    do_reset();
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0:       d = 12'h800;
        1:       d = 12'h7FF;
        default: d = 12'($urandom);
      endcase
      rm  = 1'($urandom);
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 200) begin
        if ($urandom_range(0, 4) == 0)
          step(1'b0, 12'h000, 1'b0, ($urandom_range(0, 3) != 0), res_t'(10'h000), acc);
        else
          step(1'b1, d, rm, ($urandom_range(0, 3) != 0), model(d, rm), acc);
        n++;
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL random_send_timeout: word %0h", d);
      end
    end
    drain();
    chk("random_delivered", 32'(n_deliv), 32'd40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
